// File: rtl/serial_operand_serializer.sv
// Operand-pair parallel-to-serial transmitter with first/last word framing.
// Optional macro SERIAL_SERIALIZER_LSB_FIRST_EN selects LSB-first bit order.
`timescale 1ns/1ps
module serial_operand_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_a,
  output logic             out_b,
  output logic             out_first,
  output logic             out_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic             load;
  logic             xfer;
  logic             bit_a;
  logic             bit_b;

  assign busy = (state == ST_SHIFT);

`ifdef SERIAL_SERIALIZER_LSB_FIRST_EN
  assign bit_a = sh_a[0];
  assign bit_b = sh_b[0];
`else
  assign bit_a = sh_a[WIDTH-1];
  assign bit_b = sh_b[WIDTH-1];
`endif

  // Outputs decode straight from flops, so they drop with async reset.
  assign out_valid = busy;
  assign out_a     = busy & bit_a;
  assign out_b     = busy & bit_b;
  assign out_first = busy & (cnt == '0);
  assign out_last  = busy & (cnt == LAST);

  assign in_ready = !busy | (out_last & out_ready);
  assign load     = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      cnt   <= '0;
    end else if (load) begin
      state <= ST_SHIFT;
      sh_a  <= in_a;
      sh_b  <= in_b;
      cnt   <= '0;
    end else if (xfer) begin
      if (out_last) begin
        state <= ST_IDLE;
      end else begin
`ifdef SERIAL_SERIALIZER_LSB_FIRST_EN
        sh_a <= sh_a >> 1;
        sh_b <= sh_b >> 1;
`else
        sh_a <= sh_a << 1;
        sh_b <= sh_b << 1;
`endif
        cnt  <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: doc/serial_operand_serializer.md
Name: serial_operand_serializer

Overview:
Parallel-to-serial transmitter that feeds a pair of operands into the serial comparators, one bit pair per accepted cycle.
- Accepts two WIDTH-bit operands on a valid/ready input handshake.
- Shifts them out MSB-first on a bit-level valid/ready output stream.
- Frames each word with first/last markers, so the downstream comparator knows when to clear its state.

Parameters:
WIDTH, 8, operand width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset; rst = 0 resets immediately, independent of clk.
in_valid  input  1  operand pair in_a/in_b is valid.
in_ready  output  1  block can accept an operand pair this cycle.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
out_valid  output  1  out_a/out_b carry a valid bit pair.
out_ready  input  1  downstream accepts the current bit pair.
out_a  output  1  current bit of A.
out_b  output  1  current bit of B.
out_first  output  1  current bit pair is the first (most significant) of the word.
out_last  output  1  current bit pair is the last (least significant) of the word.

Behaviour:
- Internal state:
  - FSM states ST_IDLE and ST_SHIFT.
  - Shift registers sh_a and sh_b, WIDTH bits each.
  - Bit counter cnt, $clog2(WIDTH) bits wide.
- Reset (rst = 0, asynchronous):
  - state = ST_IDLE; sh_a, sh_b, cnt = 0.
  - out_valid, out_a, out_b, out_first, out_last = 0.
  - in_ready = 1 as soon as rst is released.
- Load handshake:
  - An operand pair is accepted when in_valid & in_ready at a rising edge.
  - On acceptance: sh_a <= in_a, sh_b <= in_b, cnt <= 0, state <= ST_SHIFT.
  - Latency: out_valid rises in the cycle after acceptance.
- in_ready is combinational: (state == ST_IDLE) | (state == ST_SHIFT & out_last & out_ready).
  - The second term allows back-to-back words with no bubble.
- ST_SHIFT outputs:
  - out_valid = 1.
  - out_a = sh_a[WIDTH-1], out_b = sh_b[WIDTH-1].
  - out_first = (cnt == 0), out_last = (cnt == WIDTH-1).
- Transfer: out_valid & out_ready at a rising edge.
  - Not the last bit: shift sh_a and sh_b left by 1, cnt <= cnt + 1.
  - Last bit with a new pair accepted the same edge: load as above and stay in ST_SHIFT.
  - Last bit with no new pair: go to ST_IDLE.
- Backpressure: while out_valid & !out_ready, all outputs and internal state hold unchanged.
- ST_IDLE outputs: out_valid = 0; out_a, out_b, out_first, out_last forced to 0.
- A word takes exactly WIDTH transfer cycles; cnt never exceeds WIDTH-1 and wraps to 0 only by reload.
- in_valid while busy and not on the last transfer: ignored (in_ready = 0); the source must hold its data.
- Reset mid-word: the word is discarded and out_valid drops asynchronously. No partial word resumes after reset.
- Timing: out_valid is not combinationally dependent on in_valid; only in_ready depends on out_ready.

Optional Feature:
Macro SERIAL_SERIALIZER_LSB_FIRST_EN.
- Defined:
  - Bits are emitted LSB-first: out_a = sh_a[0], out_b = sh_b[0], shift right.
  - out_first marks bit 0 and out_last marks bit WIDTH-1.
  - Pairs with the least-significant-first comparator.
- Undefined: MSB-first as described in Behaviour.
- Handshake, framing and latency are identical in both builds.

Test Plan:
- Basic word: WIDTH=8, out_ready=1, load in_a=8'hA5, in_b=8'h3C.
  - out_a = 1,0,1,0,0,1,0,1 and out_b = 0,0,1,1,1,1,0,0 on cycles 1..8 after acceptance.
  - out_first on cycle 1 only, out_last on cycle 8 only; out_valid = 0 on cycle 9.
- Backpressure: same word with out_ready = 0 during cycles 3–5.
  - Bit 2 pair (a=1, b=1) holds for 4 cycles; total word takes 11 cycles; sequence unchanged.
- Back-to-back: in_valid held with 8'hFF/8'h00, then 8'h01/8'h80.
  - in_ready pulses on each last transfer; second word's first bit follows the previous last bit with no gap.
  - out_a = 0,0,0,0,0,0,0,1 for the second word.
- Busy input: assert in_valid with 8'h55 during cycle 4 of a word.
  - Not accepted (in_ready = 0); the current word completes intact.
  - 8'h55 is loaded only at the last transfer.
- Reset mid-word: drive rst = 0 asynchronously in cycle 5.
  - out_valid, out_first, out_last go to 0 without waiting for clk; state ST_IDLE.
  - After release, in_ready = 1 and a fresh word starts from its first bit.
- LSB build (SERIAL_SERIALIZER_LSB_FIRST_EN defined): in_a = 8'hA5.
  - out_a = 1,0,1,0,0,1,0,1 reversed per LSB order, i.e. 1,0,1,0,0,1,0,1 for the palindromic 8'hA5.
  - Also run 8'h01, which must give a 1 on cycle 1 only.
